// File: rtl/alu_result_sel_pipe.sv
// ============================================================================
// Module      : alu_result_sel_pipe
// Description : Registered NUM_IN:1 result selector with a valid/ready
//               handshake and a 2-entry skid buffer. Out-of-range selects
//               yield zero data with the err bit set. in_ready is decoded
//               from the state register only.
//               Optional macro ALU_RESULT_FLAGS_EN adds registered
//               out_zero / out_neg flags for the selected word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
`ifdef ALU_RESULT_FLAGS_EN
  output logic                    out_zero,
  output logic                    out_neg,
`endif
  input  logic                    out_ready
);

  // One captured transfer: selected word, its select and the range flag.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
`ifdef ALU_RESULT_FLAGS_EN
    logic             zero;
    logic             neg;
`endif
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e   state_q;
  payload_t main_q;
  payload_t skid_q;
  payload_t sel_pay;
  logic     in_fire;
  logic     out_fire;

  // Handshake decode depends on the state register only (no ready feed-through).
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data = main_q.data;
  assign out_sel  = main_q.sel;
  assign out_err  = main_q.err;
`ifdef ALU_RESULT_FLAGS_EN
  assign out_zero = main_q.zero;
  assign out_neg  = main_q.neg;
`endif

  // Select the addressed word; no match means the select is >= NUM_IN,
  // which leaves the data at zero and raises err. Works for non-power-of-two NUM_IN.
  always_comb begin
    sel_pay     = '0;
    sel_pay.sel = in_sel;
    sel_pay.err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_pay.data = in_data[k*WIDTH +: WIDTH];
        sel_pay.err  = 1'b0;
      end
    end
`ifdef ALU_RESULT_FLAGS_EN
    sel_pay.zero = (sel_pay.data == '0);
    sel_pay.neg  = sel_pay.data[WIDTH-1];
`endif
  end

  // Skid-buffer FSM: main register feeds the outputs, skid absorbs one extra word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_q  <= sel_pay;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= sel_pay;
          end else if (in_fire) begin
            skid_q  <= sel_pay;
            state_q <= S_FULL;
          end else if (out_fire) begin
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_sel_pipe.sv
// ============================================================================
// Module      : tb_alu_result_sel_pipe
// Description : Self-checking bench for alu_result_sel_pipe. Three instances
//               cover the default build, NUM_IN=5 and WIDTH=8/NUM_IN=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_sel_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  s;
    logic        e;
    logic        z;
    logic        n;
  } exp_a_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
    logic       e;
    logic       z;
    logic       n;
  } exp_c_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults
  logic [255:0] a_in_data;
  logic [2:0]   a_in_sel;
  logic         a_in_valid, a_in_ready;
  logic [31:0]  a_out_data;
  logic [2:0]   a_out_sel;
  logic         a_out_err, a_out_valid, a_out_ready;
  // Instance B: NUM_IN=5
  logic [159:0] b_in_data;
  logic [2:0]   b_in_sel;
  logic         b_in_valid, b_in_ready;
  logic [31:0]  b_out_data;
  logic [2:0]   b_out_sel;
  logic         b_out_err, b_out_valid, b_out_ready;
  // Instance C: WIDTH=8, NUM_IN=3, SEL_W=2
  logic [23:0]  c_in_data;
  logic [1:0]   c_in_sel;
  logic         c_in_valid, c_in_ready;
  logic [7:0]   c_out_data;
  logic [1:0]   c_out_sel;
  logic         c_out_err, c_out_valid, c_out_ready;
`ifdef ALU_RESULT_FLAGS_EN
  logic a_out_zero, a_out_neg, b_out_zero, b_out_neg, c_out_zero, c_out_neg;
`endif

  exp_a_t q_a[$];
  exp_a_t q_b[$];
  exp_c_t q_c[$];

  alu_result_sel_pipe u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
`ifdef ALU_RESULT_FLAGS_EN
    .out_zero(a_out_zero), .out_neg(a_out_neg),
`endif
    .out_ready(a_out_ready)
  );

  alu_result_sel_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
`ifdef ALU_RESULT_FLAGS_EN
    .out_zero(b_out_zero), .out_neg(b_out_neg),
`endif
    .out_ready(b_out_ready)
  );

  alu_result_sel_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_err(c_out_err), .out_valid(c_out_valid),
`ifdef ALU_RESULT_FLAGS_EN
    .out_zero(c_out_zero), .out_neg(c_out_neg),
`endif
    .out_ready(c_out_ready)
  );

  // Reference selectors
  function automatic exp_a_t model_a(input logic [255:0] d, input logic [2:0] s);
    exp_a_t r;
    r.d = d[int'(s)*32 +: 32];
    r.s = s;
    r.e = 1'b0;
    r.z = (r.d == 32'd0);
    r.n = r.d[31];
    return r;
  endfunction

  function automatic exp_a_t model_b(input logic [159:0] d, input logic [2:0] s);
    exp_a_t r;
    r.s = s;
    if (s >= 3'd5) begin
      r.d = 32'd0;
      r.e = 1'b1;
    end else begin
      r.d = d[int'(s)*32 +: 32];
      r.e = 1'b0;
    end
    r.z = (r.d == 32'd0);
    r.n = r.d[31];
    return r;
  endfunction

  function automatic exp_c_t model_c(input logic [23:0] d, input logic [1:0] s);
    exp_c_t r;
    r.s = s;
    if (s == 2'd3) begin
      r.d = 8'd0;
      r.e = 1'b1;
    end else begin
      r.d = d[int'(s)*8 +: 8];
      r.e = 1'b0;
    end
    r.z = (r.d == 8'd0);
    r.n = r.d[7];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_out_sel, a_out_err} !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got v=%b r=%b d=%h s=%0d e=%b, expected v=0 r=1 d=0 s=0 e=0",
               a_out_valid, a_in_ready, a_out_data, a_out_sel, a_out_err);
    end
    checks++;
    if ({b_out_valid, b_in_ready, c_out_valid, c_in_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_bc: got %b expected 0101", {b_out_valid, b_in_ready, c_out_valid, c_in_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release: got v/r=%b expected 01", {a_out_valid, a_in_ready});
    end
  endtask

  task automatic test_basic_select();
    exp_a_t e;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'h1000_0000 + k;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== (q_a.size() != 0)) begin
        errors++;
        $display("FAIL basic_valid: cycle %0d got %b expected %b", cyc, a_out_valid, q_a.size() != 0);
      end
      if (a_out_valid === 1'b1 && q_a.size() != 0) begin
        e = q_a[0];
        checks++;
        if ({a_out_data, a_out_sel, a_out_err} !== {e.d, e.s, e.e}) begin
          errors++;
          $display("FAIL basic_data: got %h/%0d/%b expected %h/%0d/%b",
                   a_out_data, a_out_sel, a_out_err, e.d, e.s, e.e);
        end
        void'(q_a.pop_front());
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready: cycle %0d got %b expected 1", cyc, a_in_ready);
      end
      a_in_valid = (cyc < 8);
      a_in_sel   = 3'(cyc);
      if (a_in_valid && a_in_ready) q_a.push_back(model_a(a_in_data, a_in_sel));
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_out_of_range();
    exp_a_t e;
    logic [2:0] sels [4] = '{3'd6, 3'd4, 3'd5, 3'd7};
    b_in_data   = {160{1'b1}};
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      checks++;
      if (b_out_valid !== (q_b.size() != 0)) begin
        errors++;
        $display("FAIL range_valid: cycle %0d got %b expected %b", cyc, b_out_valid, q_b.size() != 0);
      end
      if (b_out_valid === 1'b1 && q_b.size() != 0) begin
        e = q_b[0];
        checks++;
        if ({b_out_data, b_out_sel, b_out_err} !== {e.d, e.s, e.e}) begin
          errors++;
          $display("FAIL range_data: got %h/%0d/%b expected %h/%0d/%b",
                   b_out_data, b_out_sel, b_out_err, e.d, e.s, e.e);
        end
`ifdef ALU_RESULT_FLAGS_EN
        checks++;
        if ({b_out_zero, b_out_neg} !== {e.z, e.n}) begin
          errors++;
          $display("FAIL range_flags: got z/n=%b expected %b", {b_out_zero, b_out_neg}, {e.z, e.n});
        end
`endif
        void'(q_b.pop_front());
      end
      b_in_valid = (cyc < 4);
      b_in_sel   = (cyc < 4) ? sels[cyc] : 3'd0;
      if (b_in_valid && b_in_ready) q_b.push_back(model_b(b_in_data, b_in_sel));
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w2, w5;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'hA5A5_0000 + 32'(k * 17);
    w2 = 32'hA5A5_0000 + 32'd34;
    w5 = 32'hA5A5_0000 + 32'd85;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_sel = 3'd2;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data} !== {1'b1, 1'b1, w2}) begin
      errors++;
      $display("FAIL bp_first: got v=%b r=%b d=%h expected v=1 r=1 d=%h", a_out_valid, a_in_ready, a_out_data, w2);
    end
    a_in_sel = 3'd5;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_data, a_out_sel} !== {1'b1, 1'b0, w2, 3'd2}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b r=%b d=%h s=%0d expected v=1 r=0 d=%h s=2",
                 cyc, a_out_valid, a_in_ready, a_out_data, a_out_sel, w2);
      end
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_out_sel} !== {1'b1, 1'b1, w5, 3'd5}) begin
      errors++;
      $display("FAIL bp_second: got v=%b r=%b d=%h s=%0d expected v=1 r=1 d=%h s=5",
               a_out_valid, a_in_ready, a_out_data, a_out_sel, w5);
    end
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drain: got v/r=%b expected 01", {a_out_valid, a_in_ready});
    end
  endtask

  task automatic test_random_stall();
    exp_a_t e, prev;
    logic   prev_stall = 1'b0;
    int     sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        checks++;
        if ({a_out_valid, a_out_data, a_out_sel, a_out_err} !== {1'b1, prev.d, prev.s, prev.e}) begin
          errors++;
          $display("FAIL rand_stable: got v=%b d=%h expected v=1 d=%h", a_out_valid, a_out_data, prev.d);
        end
      end
      checks++;
      if (a_out_valid !== (q_a.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid: got %b expected %b", a_out_valid, q_a.size() != 0);
      end
      a_out_ready = ($urandom_range(0, 9) < 7);
      if (a_out_valid === 1'b1 && q_a.size() != 0) begin
        e = q_a[0];
        checks++;
        if ({a_out_data, a_out_sel, a_out_err} !== {e.d, e.s, e.e}) begin
          errors++;
          $display("FAIL rand_data: got %h/%0d expected %h/%0d", a_out_data, a_out_sel, e.d, e.s);
        end
        if (a_out_ready) begin
          void'(q_a.pop_front());
          rcvd++;
        end
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev.d = a_out_data; prev.s = a_out_sel; prev.e = a_out_err;
      for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = $urandom;
      a_in_sel   = 3'($urandom_range(0, 7));
      a_in_valid = (sent < 10000) && ($urandom_range(0, 9) < 7);
      if (a_in_valid && a_in_ready) begin
        q_a.push_back(model_a(a_in_data, a_in_sel));
        sent++;
      end
    end
    a_in_valid = 1'b0;
    checks++;
    if (rcvd != 10000 || q_a.size() != 0) begin
      errors++;
      $display("FAIL rand_count: received %0d left %0d, expected 10000 and 0", rcvd, q_a.size());
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_extra: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_reset_in_full();
    int seen = 0;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'hC0DE_0000 + k;
    q_a.delete();
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_sel = 3'd3;
    @(negedge clk);
    a_in_sel = 3'd6;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL full_reach: got v/r=%b expected 10", {a_out_valid, a_in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_out_sel} !== {1'b0, 1'b1, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL full_reset: got v=%b r=%b d=%h s=%0d expected v=0 r=1 d=0 s=0",
               a_out_valid, a_in_ready, a_out_data, a_out_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_sel = 3'd1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (a_out_valid === 1'b1) begin
        seen++;
        checks++;
        if (a_out_data !== 32'hC0DE_0001) begin
          errors++;
          $display("FAIL full_after: got %h expected c0de0001", a_out_data);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL full_count: got %0d words expected 1", seen);
    end
  endtask

  task automatic test_width();
    exp_c_t e;
    logic [1:0] sels [3] = '{2'd2, 2'd0, 2'd3};
    c_in_data   = {8'h82, 8'h81, 8'h80};
    c_out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      checks++;
      if (c_out_valid !== (q_c.size() != 0)) begin
        errors++;
        $display("FAIL width_valid: got %b expected %b", c_out_valid, q_c.size() != 0);
      end
      if (c_out_valid === 1'b1 && q_c.size() != 0) begin
        e = q_c[0];
        checks++;
        if ({c_out_data, c_out_sel, c_out_err} !== {e.d, e.s, e.e}) begin
          errors++;
          $display("FAIL width_data: got %h/%0d/%b expected %h/%0d/%b",
                   c_out_data, c_out_sel, c_out_err, e.d, e.s, e.e);
        end
`ifdef ALU_RESULT_FLAGS_EN
        checks++;
        if ({c_out_zero, c_out_neg} !== {e.z, e.n}) begin
          errors++;
          $display("FAIL width_flags: got z/n=%b expected %b", {c_out_zero, c_out_neg}, {e.z, e.n});
        end
`endif
        void'(q_c.pop_front());
      end
      c_in_valid = (cyc < 3);
      c_in_sel   = (cyc < 3) ? sels[cyc] : 2'd0;
      if (c_in_valid && c_in_ready) q_c.push_back(model_c(c_in_data, c_in_sel));
    end
    c_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_select();
    test_out_of_range();
    test_backpressure();
    test_random_stall();
    test_reset_in_full();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
- Parametrised, registered N:1 result selector with a valid/ready handshake. Successor to the ALU's fixed 8-input, 32-bit combinational result mux.
- Sits between the ALU functional units and the writeback/flag stage.
- Picks one of NUM_IN operand words by a binary select and registers the result. A 2-entry skid buffer gives full throughput under backpressure, with no combinational ready path.
- Flags out-of-range selects.

Parameters:
- WIDTH, 32, data width of each input word and of the output.
- NUM_IN, 8, number of input words; any value 2..64 (not required to be a power of two).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  NUM_IN*WIDTH  packed inputs; word k = in_data[k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary index of the word to pass.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts a transfer this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  in_sel captured with out_data.
- out_err  output  1  captured select was >= NUM_IN.
- out_valid  output  1  out_* valid.
- out_ready  input  1  downstream accepts out_* this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Transfers:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
- Selection:
  - Computed combinationally from in_data/in_sel at input fire, then registered.
  - If in_sel >= NUM_IN, the captured data is all zeros and the captured err bit is 1.
- Storage: main register (drives out_*) plus one skid register, each holding {data, sel, err}.
- FSM states: EMPTY, ONE, FULL.
  - EMPTY: out_valid=0, in_ready=1.
    - Input fire -> load main, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input fire and output fire -> load main with the new word, stay in ONE.
    - Input fire, no output fire -> load skid, go to FULL.
    - Output fire only -> go to EMPTY.
    - Neither -> hold.
  - FULL: out_valid=1, in_ready=0.
    - Output fire -> main<=skid, go to ONE.
    - Otherwise hold.
- in_ready is decoded from the state register only; there is no combinational path from out_ready or in_valid.
- Latency: 1 cycle from input fire to out_valid when starting from EMPTY or draining from ONE.
- Throughput: 1 word/cycle while out_ready=1.
- out_* stays stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- in_sel and in_data are don't-care when in_valid=0.
- Reset (asynchronous assert, any state, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1 (follows from EMPTY).
  - out_data=0, out_sel=0, out_err=0.
  - Skid contents cleared to 0.
  - Any held words are discarded.

Optional Feature:
- Macro: ALU_RESULT_FLAGS_EN.
- When defined, add two outputs, registered alongside main/skid and following the same handshake and reset (0):
  - out_zero (1 bit): selected word == 0.
  - out_neg (1 bit): selected word MSB (bit WIDTH-1).
  - For an out-of-range select: out_zero=1, out_neg=0.
- When undefined, the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Basic select: defaults, out_ready=1, word k = 32'h1000_0000+k, send sel=0..7 back-to-back -> out_data 32'h1000_0000..32'h1000_0007 on consecutive cycles, 1-cycle latency, out_err=0, in_ready stays 1.
- Out-of-range select: NUM_IN=5, SEL_W=3, send sel=6 with all words 32'hFFFF_FFFF -> out_data=0, out_err=1, out_sel=3'd6; with the flags macro, out_zero=1 and out_neg=0.
- Backpressure: hold out_ready=0, send sel=2 then sel=5 -> in_ready drops to 0 the cycle after the second fire and out_data holds word 2. Raise out_ready -> word 2 then word 5, in_ready returns to 1.
- Random stall: random in_valid/out_ready over 10k transfers against a scoreboard -> exact FIFO order, no loss or duplication, out_* stable while stalled.
- Reset in FULL: reach FULL, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0 and in_ready=1 immediately. After release, a sel=1 transfer yields only word 1.
- Width generality: WIDTH=8, NUM_IN=3, SEL_W=2, word k = 8'h80|k, sel=2 -> out_data=8'h82; with the flags macro, out_neg=1.
